polar_enc_core: RTL and testbench

Frame-based polar encoder computing x = u·F^{⊗n}, with F = [[1,0],[1,1]] and code length N ∈ {128, 256, 512}. It is the transmit-side counterpart of the SC decoder datapath and produces reference codewords for decoder test and loopback. Bits stream in P bits per beat and are buffered in a 512-bit register. The block applies one butterfly stage per cycle, then streams the codeword out P bits per beat under valid/ready backpressure.

---
 rtl/polar_pkg.sv | 54 +++++
 rtl/polar_bfly_stage.sv | 36 +++
 rtl/polar_enc_core.sv | 140 ++++++++++++++
 tb/tb_polar_enc_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | polar_pkg                                                              |
// | Shared sizes, code-length encodings, FSM states and helper functions   |
// | for the polar encoder.                                                 |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package polar_pkg;

   localparam int N_MAX      = 512;
   localparam int P          = 8;
   localparam int LOG2_N_MAX = 9;
   localparam int LOG2_P     = 3;
   localparam int BEAT_W     = LOG2_N_MAX - LOG2_P;
   localparam int N_W        = LOG2_N_MAX + 1;
   localparam int STAGE_W    = 4;

   localparam logic [1:0] N_128 = 2'd0;
   localparam logic [1:0] N_256 = 2'd1;
   localparam logic [1:0] N_512 = 2'd2;
   localparam logic [1:0] N_ILL = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ENC   = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   typedef struct packed {
      logic [N_W-1:0]     n;
      logic [STAGE_W-1:0] log2n;
   } n_cfg_t;

   // The illegal selector falls back to the largest code length.
   function automatic n_cfg_t n_of(input logic [1:0] sel);
      n_cfg_t c;
      case (sel)
         N_128:   begin c.n = 10'd128; c.log2n = 4'd7; end
         N_256:   begin c.n = 10'd256; c.log2n = 4'd8; end
         default: begin c.n = 10'd512; c.log2n = 4'd9; end
      endcase
      return c;
   endfunction

   function automatic logic [LOG2_N_MAX-1:0] bitrev_n(input logic [LOG2_N_MAX-1:0] idx,
                                                      input logic [STAGE_W-1:0]    log2n);
      logic [LOG2_N_MAX-1:0] r;
      for (int b = 0; b < LOG2_N_MAX; b++) r[b] = idx[LOG2_N_MAX-1-b];
      return r >> (STAGE_W'(LOG2_N_MAX) - log2n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/polar_bfly_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | polar_bfly_stage                                                       |
// | One combinational polar butterfly stage over the frame buffer.         |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module polar_bfly_stage
   import polar_pkg::*;
(
   input  logic [N_MAX-1:0]   buf_i,
   input  logic [STAGE_W-1:0] stage_i,
   input  logic [N_W-1:0]     n_i,
   output logic [N_MAX-1:0]   buf_o
);

   logic [N_MAX-1:0] stg [LOG2_N_MAX];

   for (genvar s = 0; s < LOG2_N_MAX; s++) begin : g_stage
      for (genvar i = 0; i < N_MAX; i++) begin : g_bit
         if (((i >> s) & 1) == 0) begin : g_upper
            assign stg[s][i] = buf_i[i] ^ (buf_i[i + (1 << s)] & (N_W'(i) < n_i));
         end else begin : g_lower
            assign stg[s][i] = buf_i[i];
         end
      end
   end

   always_comb begin
      buf_o = buf_i;
      for (int k = 0; k < LOG2_N_MAX; k++) begin
         if (stage_i == STAGE_W'(k)) buf_o = stg[k];
      end
   end

endmodule
`default_nettype wire

// File: rtl/polar_enc_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | polar_enc_core                                                         |
// | Frame polar encoder x = u*F^(xn), N in {128,256,512}, P-bit streaming. |
// | Define POLAR_ENC_BITREV_EN for bit-reversed output ordering.           |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module polar_enc_core
   import polar_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   n_sel,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [P-1:0] in_u,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [P-1:0] out_x,
   output logic         out_last,
   output logic         frame_err
);

   state_e             state_q, state_d;
   n_cfg_t             cfg_q, cfg_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [N_MAX-1:0]   buf_q, buf_d;
   logic               err_q, err_d;

   n_cfg_t             in_cfg;
   logic [BEAT_W-1:0]  last_beat;
   logic [N_MAX-1:0]   bfly_buf;
   logic [P-1:0]       rd_x;
   logic               in_hs;

   assign in_cfg    = n_of(n_sel);
   assign last_beat = BEAT_W'((cfg_q.n >> LOG2_P) - 1'b1);
   // rst_n gates ready so the sender sees it low throughout reset.
   assign in_ready  = rst_n && ((state_q == S_IDLE) || (state_q == S_LOAD));
   assign in_hs     = in_valid && in_ready;

   polar_bfly_stage u_bfly (
      .buf_i   (buf_q),
      .stage_i (stage_q),
      .n_i     (cfg_q.n),
      .buf_o   (bfly_buf)
   );

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      beat_d  = beat_q;
      stage_d = stage_q;
      buf_d   = buf_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_hs) begin
               cfg_d           = in_cfg;
               buf_d[P-1:0]    = in_u;
               beat_d          = BEAT_W'(1);
               err_d           = (n_sel == N_ILL) || in_last;
               state_d         = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_hs) begin
               buf_d[{beat_q, {LOG2_P{1'b0}}} +: P] = in_u;
               err_d = in_last != (beat_q == last_beat);
               if (beat_q == last_beat) begin
                  state_d = S_ENC;
                  stage_d = '0;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + 1'b1;
               end
            end
         end
         S_ENC: begin
            buf_d   = bfly_buf;
            stage_d = stage_q + 1'b1;
            if (stage_q == cfg_q.log2n - 4'd1) begin
               state_d = S_DRAIN;
               stage_d = '0;
               beat_d  = '0;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (beat_q == last_beat) begin
                  state_d = S_IDLE;
                  buf_d   = '0;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cfg_q   <= '0;
         beat_q  <= '0;
         stage_q <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         beat_q  <= beat_d;
         stage_q <= stage_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

`ifdef POLAR_ENC_BITREV_EN
   always_comb begin
      rd_x = '0;
      for (int k = 0; k < P; k++) begin
         rd_x[k] = buf_q[bitrev_n({beat_q, LOG2_P'(k)}, cfg_q.log2n)];
      end
   end
`else
   assign rd_x = buf_q[{beat_q, {LOG2_P{1'b0}}} +: P];
`endif

   assign out_valid = (state_q == S_DRAIN);
   assign out_last  = out_valid && (beat_q == last_beat);
   assign out_x     = out_valid ? rd_x : '0;
   assign frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_polar_enc_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_polar_enc_core                                                      |
// | Randomized self-checking bench for polar_enc_core.                     |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_polar_enc_core;
   import polar_pkg::*;

`ifdef POLAR_ENC_BITREV_EN
   localparam bit BITREV = 1'b1;
`else
   localparam bit BITREV = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   n_sel;
   logic         in_valid;
   logic         in_ready;
   logic [P-1:0] in_u;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [P-1:0] out_x;
   logic         out_last;
   logic         frame_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int fr_n = 128;
   logic [N_MAX-1:0] u_vec;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   polar_enc_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .n_sel     (n_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_u      (in_u),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int log2i(input int n);
      int l = 0;
      while ((1 << l) < n) l++;
      return l;
   endfunction

   // x[i] is the XOR of u[j] over every j whose set bits contain those of i.
   function automatic logic [N_MAX-1:0] ref_encode(input logic [N_MAX-1:0] u, input int n);
      logic [N_MAX-1:0] x;
      logic acc;
      x = '0;
      for (int i = 0; i < n; i++) begin
         acc = 1'b0;
         for (int j = i; j < n; j++) if ((i & j) == i) acc ^= u[j];
         x[i] = acc;
      end
      return x;
   endfunction

   function automatic int out_index(input int o, input int lg, input bit brev);
      int r;
      if (!brev) return o;
      r = 0;
      for (int b = 0; b < lg; b++) if (((o >> b) & 1) == 1) r |= 1 << (lg - 1 - b);
      return r;
   endfunction

   function automatic logic [N_MAX-1:0] rand_u();
      logic [N_MAX-1:0] v;
      for (int w = 0; w < N_MAX / 32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic send_frame(input logic [1:0] sel, input int bad_last, input bit no_last,
                             input bit gaps);
      int n, nb, guard;
      logic exp_err;
      n  = (sel == N_128) ? 128 : (sel == N_256) ? 256 : 512;
      nb = n / P;
      for (int b = 0; b < nb; b++) begin
         if (gaps && b > 0 && $urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         n_sel    = (b == 0) ? sel : 2'($urandom_range(3));
         in_valid = 1'b1;
         in_u     = u_vec[b*P +: P];
         in_last  = (b == nb - 1) ? !no_last : (b == bad_last);
         exp_err  = (b == 0 && sel == N_ILL) || (in_last != (b == nb - 1));
         guard = 0;
         while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         chk_eq("in_ready_wait", in_ready, 1);
         hs_cyc = cyc;
         @(negedge clk);
         chk_eq("frame_err", frame_err, exp_err);
         chk_eq("in_ready_after", in_ready, (b != nb - 1));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      fr_n     = n;
   endtask

   task automatic recv_frame(input bit rnd_ready);
      logic [N_MAX-1:0] xm;
      logic [P-1:0] sv_x, ex;
      logic sv_last;
      int nb, lg, beat, guard;
      bit first, stalled, r;
      xm = ref_encode(u_vec, fr_n);
      nb = fr_n / P;
      lg = log2i(fr_n);
      beat = 0; first = 1'b1; stalled = 1'b0; guard = 0;
      sv_x = '0; sv_last = 1'b0;
      while (beat < nb && guard < 20000) begin
         if (stalled) begin
            chk_eq("stall_valid", out_valid, 1);
            chk_eq("stall_x", out_x, sv_x);
            chk_eq("stall_last", out_last, sv_last);
         end
         stalled = 1'b0;
         if (out_valid && first) begin
            chk_eq("latency", cyc - hs_cyc, lg + 1);
            first = 1'b0;
         end
         r = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
         out_ready = r;
         if (out_valid) begin
            if (r) begin
               for (int k = 0; k < P; k++) ex[k] = xm[out_index(beat * P + k, lg, BITREV)];
               chk_eq("out_x", out_x, ex);
               chk_eq("out_last", out_last, (beat == nb - 1));
               beat++;
            end else begin
               stalled = 1'b1;
               sv_x    = out_x;
               sv_last = out_last;
            end
         end
         guard++;
         @(negedge clk);
      end
      if (beat < nb) chk_eq("recv_timeout", beat, nb);
      out_ready = 1'b0;
      chk_eq("valid_after", out_valid, 0);
      chk_eq("in_ready_idle", in_ready, 1);
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      chk_eq("rst_in_ready", in_ready, 0);
      chk_eq("rst_out_valid", out_valid, 0);
      chk_eq("rst_out_x", out_x, 0);
      chk_eq("rst_out_last", out_last, 0);
      chk_eq("rst_frame_err", frame_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk_eq("release_in_ready", in_ready, 1);
      @(negedge clk);
   endtask

   initial begin
      int guard;
      n_sel = '0; in_valid = 1'b0; in_u = '0; in_last = 1'b0; out_ready = 1'b0;
      u_vec = '0;
      repeat (3) @(negedge clk);
      chk_eq("reset_in_ready", in_ready, 0);
      chk_eq("reset_out_valid", out_valid, 0);
      chk_eq("reset_out_x", out_x, 0);
      chk_eq("reset_out_last", out_last, 0);
      chk_eq("reset_frame_err", frame_err, 0);
      rst_n = 1'b1;
      #1 chk_eq("first_in_ready", in_ready, 1);
      @(negedge clk);

      u_vec = '0; u_vec[0] = 1'b1;
      send_frame(N_128, -1, 1'b0, 1'b0); recv_frame(1'b0);
      u_vec = '0; u_vec[127] = 1'b1;
      send_frame(N_128, -1, 1'b0, 1'b0); recv_frame(1'b0);
      u_vec = rand_u();
      send_frame(N_512, -1, 1'b0, 1'b1); recv_frame(1'b1);
      u_vec = rand_u();
      send_frame(N_ILL, -1, 1'b0, 1'b0); recv_frame(1'b1);
      u_vec = rand_u();
      send_frame(N_128, 5, 1'b0, 1'b1); recv_frame(1'b0);
      u_vec = rand_u();
      send_frame(N_256, -1, 1'b1, 1'b0); recv_frame(1'b1);

      u_vec = rand_u();
      send_frame(N_256, -1, 1'b0, 1'b0);
      @(negedge clk);
      pulse_reset();
      u_vec = '0; u_vec[127] = 1'b1;
      send_frame(N_128, -1, 1'b0, 1'b0); recv_frame(1'b0);

      u_vec = rand_u();
      send_frame(N_128, -1, 1'b0, 1'b0);
      guard = 0;
      while (!out_valid && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      chk_eq("drain_reached", out_valid, 1);
      pulse_reset();
      u_vec = rand_u();
      send_frame(N_256, -1, 1'b0, 1'b1); recv_frame(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
